// File: rtl/signed_or_unsigned_div.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned
// per transaction, with valid/ready handshakes on operand and result sides.
module signed_or_unsigned_div #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(n);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  prem_q, prem_d;
  logic [n-1:0]  dvd_q, dvd_d;
  logic [n-1:0]  dvs_q, dvs_d;
  logic [n-1:0]  a_q, a_d;
  logic          sq_q, sq_d;
  logic          sr_q, sr_d;
  logic [n-1:0]  quot_q, quot_d;
  logic [n-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [n:0]    shifted;
  logic          ge;
  logic [n-1:0]  prem_nxt;
  logic [n-1:0]  dvd_nxt;

  // One restoring step; the difference always fits in n bits because the
  // partial remainder is kept below the divisor magnitude.
  always_comb begin
    shifted  = {prem_q, dvd_q[n-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    prem_nxt = ge ? (shifted[n-1:0] - dvs_q) : shifted[n-1:0];
    dvd_nxt  = {dvd_q[n-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (arg_vld) begin
          a_d     = a;
          dvd_d   = (signed_div && a[n-1]) ? ('0 - a) : a;
          dvs_d   = (signed_div && b[n-1]) ? ('0 - b) : b;
          prem_d  = '0;
          sq_d    = signed_div & (a[n-1] ^ b[n-1]);
          sr_d    = signed_div & a[n-1];
          cnt_d   = CW'(n - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        prem_d = prem_nxt;
        dvd_d  = dvd_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          if (dvs_q == '0) begin
            quot_d = '1;
            rem_d  = a_q;
            dz_d   = 1'b1;
          end else begin
            // smin / -1 wraps back to smin through the negation.
            quot_d = sq_q ? ('0 - dvd_nxt) : dvd_nxt;
            rem_d  = sr_q ? ('0 - prem_nxt) : prem_nxt;
            dz_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign arg_rdy     = (state_q == IDLE);
  assign res_vld     = (state_q == DONE);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Bench for signed_or_unsigned_div at n=4: directed vectors, backpressure,
// mid-calculation reset and an exhaustive sweep against a behavioural model.
module tb_signed_or_unsigned_div;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         arg_vld;
  logic         arg_rdy;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_div;
  logic         res_vld;
  logic         res_rdy;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         div_by_zero;

  signed_or_unsigned_div #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .arg_vld    (arg_vld),
    .arg_rdy    (arg_rdy),
    .a          (a),
    .b          (b),
    .signed_div (signed_div),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    exp_t         e;
  } vec_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t golden(input logic [N-1:0] ga, input logic [N-1:0] gb, input logic s);
    exp_t e;
    int sa, sb, q, r;
    if (gb == '0) begin
      e.q = '1; e.r = ga; e.dz = 1'b1;
      return e;
    end
    if (s) begin
      sa = int'($signed(ga));
      sb = int'($signed(gb));
      if (sa == -8 && sb == -1) begin
        q = -8; r = 0;
      end else begin
        q = sa / sb; r = sa % sb;
      end
    end else begin
      sa = int'(ga);
      sb = int'(gb);
      q = sa / sb; r = sa % sb;
    end
    e.q = q[N-1:0]; e.r = r[N-1:0]; e.dz = 1'b0;
    return e;
  endfunction

  // Issue one operation, check latency, optionally stall with ignored
  // arg_vld pulses, then consume and compare against the scoreboard head.
  task automatic run_one(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic ts,
                         input exp_t e, input int stall, input bit pulses, input bit chk_lat);
    int lat;
    exp_t h;
    logic [N-1:0] q0, r0;
    logic dz0;
    a = ta; b = tb_; signed_div = ts; arg_vld = 1'b1;
    scb.push_back(e);
    @(posedge clk); #1;
    arg_vld = 1'b0; a = $urandom_range(0, 15); b = $urandom_range(0, 15);
    lat = 0;
    while (!res_vld && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (chk_lat) chk("latency", lat, N);
    else if (lat >= 50) chk("timeout", lat, N);
    q0 = quot; r0 = rem; dz0 = div_by_zero;
    for (int i = 0; i < stall; i++) begin
      if (pulses) begin
        arg_vld = 1'b1; a = 4'h3; b = 4'h1; signed_div = 1'b0;
      end
      @(posedge clk); #1;
      if (pulses) begin
        chk("stall_vld", int'(res_vld), 1);
        chk("stall_rdy", int'(arg_rdy), 0);
        chk("stall_quot", int'(quot), int'(q0));
        chk("stall_rem", int'(rem), int'(r0));
        chk("stall_dz", int'(div_by_zero), int'(dz0));
      end
    end
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    if (scb.size() == 0) begin
      chk("scb_empty", 1, 0);
    end else begin
      h = scb.pop_front();
      chk("res_vld", int'(res_vld), 1);
      chk("quot", int'(quot), int'(h.q));
      chk("rem", int'(rem), int'(h.r));
      chk("dz", int'(div_by_zero), int'(h.dz));
    end
    @(posedge clk); #1;
    res_rdy = 1'b0;
    chk("vld_after", int'(res_vld), 0);
    chk("rdy_after", int'(arg_rdy), 1);
  endtask

  vec_t vecs[8];
  int   seen;

  initial begin
    vecs[0] = '{4'd13, 4'd3,  1'b0, '{4'd4,  4'd1,  1'b0}};
    vecs[1] = '{4'h9,  4'd2,  1'b1, '{4'hD,  4'hF,  1'b0}};
    vecs[2] = '{4'd7,  4'hE,  1'b1, '{4'hD,  4'h1,  1'b0}};
    vecs[3] = '{4'h8,  4'hF,  1'b1, '{4'h8,  4'h0,  1'b0}};
    vecs[4] = '{4'h5,  4'h0,  1'b0, '{4'hF,  4'h5,  1'b1}};
    vecs[5] = '{4'h5,  4'h0,  1'b1, '{4'hF,  4'h5,  1'b1}};
    vecs[6] = '{4'hF,  4'hF,  1'b0, '{4'h1,  4'h0,  1'b0}};
    vecs[7] = '{4'h7,  4'h8,  1'b0, '{4'h0,  4'h7,  1'b0}};

    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0; a = '0; b = '0; signed_div = 1'b0;
    #12;
    chk("rst_arg_rdy", int'(arg_rdy), 1);
    chk("rst_res_vld", int'(res_vld), 0);
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_one(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, 0, 1'b0, 1'b1);

    // Backpressure: five stalled cycles with ignored operand pulses.
    run_one(4'd13, 4'd3, 1'b0, '{4'd4, 4'd1, 1'b0}, 5, 1'b1, 1'b1);

    // Reset mid-calculation: the operation must vanish.
    a = 4'd13; b = 4'd3; signed_div = 1'b0; arg_vld = 1'b1;
    @(posedge clk); #1;
    arg_vld = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_res_vld", int'(res_vld), 0);
    chk("midrst_arg_rdy", int'(arg_rdy), 1);
    chk("midrst_quot", int'(quot), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_vld) seen++;
    end
    chk("midrst_no_result", seen, 0);

    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          run_one(ia[N-1:0], ib[N-1:0], s[0], golden(ia[N-1:0], ib[N-1:0], s[0]),
                  int'($urandom_range(0, 3)), 1'b0, 1'b1);

    chk("scb_drained", scb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_or_unsigned_div.md
Name: signed_or_unsigned_div

Overview:
Sequential restoring divider, the inverse operation of the team's signed/unsigned multiplier. It divides two n-bit operands and returns an n-bit quotient and an n-bit remainder, signed or unsigned, selected per transaction. It produces one quotient bit per clock. Valid/ready handshakes on both sides let it sit in an arithmetic pipeline next to the multiplier.

Parameters:
n, 8, operand/quotient/remainder width in bits (n >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
arg_vld  input  1  operands valid
arg_rdy  output  1  block can accept operands
a  input  n  dividend
b  input  n  divisor
signed_div  input  1  1 = two's-complement division, 0 = unsigned
res_vld  output  1  result valid
res_rdy  input  1  consumer accepts result
quot  output  n  quotient
rem  output  n  remainder
div_by_zero  output  1  result came from b == 0

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, res_vld=0, quot=0, rem=0, div_by_zero=0, arg_rdy=1. Reset mid-calculation discards the operation; no result is ever delivered for it.
- States:
  - IDLE: arg_rdy=1, res_vld=0. On arg_vld&&arg_rdy at edge k:
    - latch a, b, signed_div;
    - load |a| and |b| (magnitude when signed_div=1, raw when 0);
    - record sign_q = a[n-1]^b[n-1] and sign_r = a[n-1] (both forced 0 when unsigned);
    - set counter = n-1; go to CALC.
  - CALC: arg_rdy=0, res_vld=0. Each edge performs one restoring step:
    - shift {partial_rem, dividend} left by 1;
    - trial-subtract the divisor (n+1-bit compare);
    - quotient bit = no-borrow;
    - decrement counter.
    - On the edge where counter==0 (edge k+n), register the final quot/rem with sign correction and div_by_zero, then go to DONE.
  - DONE: res_vld=1, arg_rdy=0; quot/rem/div_by_zero held stable. On res_rdy=1 at an edge, go to IDLE with res_vld=0. quot/rem keep their last values after that.
- Latency: res_vld high from edge k+n exactly, independent of operand values. Minimum initiation interval is n+2 cycles: new operands are never accepted in the same cycle a result is consumed.
- Arithmetic:
  - Truncation toward zero (C semantics): a = quot*b + rem, |rem| < |b|.
  - Signed: quot negated when sign_q=1; rem negated when sign_r=1. Remainder sign follows the dividend.
  - Signed overflow smin / -1: quot = smin (wraps), rem = 0. div_by_zero=0.
  - Divide by zero, both modes: quot = all ones, rem = latched a unmodified, div_by_zero=1. Latency stays the same n cycles.
- Magnitude of smin is 2^(n-1), held in the internal n-bit unsigned datapath without loss.
- Operand inputs a, b, signed_div are don't-care outside the accepting edge.
- arg_rdy is a function of state only; it does not depend combinationally on arg_vld.
- res_vld does not depend combinationally on res_rdy.

Test Plan:
- n=4, unsigned a=13, b=3 -> res_vld after exactly 4 edges post-accept, quot=4, rem=1, div_by_zero=0.
- n=4, signed a=-7 (4'b1001), b=2 -> quot=4'b1101 (-3), rem=4'b1111 (-1); also a=7, b=-2 -> quot=-3, rem=1.
- n=4, signed a=-8, b=-1 -> quot=4'b1000, rem=0, div_by_zero=0.
- n=4, b=0, a=4'b0101, in both signed_div=0 and 1 -> quot=4'b1111, rem=4'b0101, div_by_zero=1.
- Backpressure and reset:
  - hold res_rdy=0 for 5 cycles in DONE -> res_vld stays 1, outputs stable, arg_rdy=0, arg_vld pulses ignored;
  - assert rst mid-CALC -> res_vld=0 and arg_rdy=1 immediately, with no result delivered.
- Exhaustive n=4 sweep of all a, b in both modes with random res_rdy stalls -> each result matches the golden model (truncating division plus the divide-by-zero and overflow rules). Results come back in order, exactly one per accepted operand pair.
